// File: rtl/segrw_arb2_ctl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : segrw_arb2_ctl_if                                          |
// | Description : Bundle of the two requester ports (A/B request and         |
// |               response channels) and the SEG_rw datapath control lines   |
// |               used by segrw_arb2_ctl.                                    |
// | Ports       : a_/b_ valid, ready, addr, dataW, write   request channel   |
// |               a_/b_ rvalid, rready, rdata             response channel   |
// |               seg_state, seg_statecase, seg_addr_d,                      |
// |               seg_dataW_d, seg_write_d, seg_dataR_d   datapath side      |
// | Modports    : slave  - the controller                                    |
// |               master - the environment (requesters and datapath)         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface segrw_arb2_ctl_if #(
   parameter int awidth = 7,
   parameter int dwidth = 7
);
   logic              a_valid;
   logic              a_ready;
   logic [awidth-1:0] a_addr;
   logic [dwidth-1:0] a_dataW;
   logic              a_write;
   logic              a_rvalid;
   logic              a_rready;
   logic [dwidth-1:0] a_rdata;

   logic              b_valid;
   logic              b_ready;
   logic [awidth-1:0] b_addr;
   logic [dwidth-1:0] b_dataW;
   logic              b_write;
   logic              b_rvalid;
   logic              b_rready;
   logic [dwidth-1:0] b_rdata;

   logic              seg_state;
   logic [1:0]        seg_statecase;
   logic [awidth-1:0] seg_addr_d;
   logic [dwidth-1:0] seg_dataW_d;
   logic              seg_write_d;
   logic [dwidth-1:0] seg_dataR_d;

   modport slave (
      input  a_valid, a_addr, a_dataW, a_write, a_rready,
      input  b_valid, b_addr, b_dataW, b_write, b_rready,
      output a_ready, a_rvalid, a_rdata,
      output b_ready, b_rvalid, b_rdata,
      output seg_state, seg_statecase, seg_addr_d, seg_dataW_d, seg_write_d,
      input  seg_dataR_d
   );

   modport master (
      output a_valid, a_addr, a_dataW, a_write, a_rready,
      output b_valid, b_addr, b_dataW, b_write, b_rready,
      input  a_ready, a_rvalid, a_rdata,
      input  b_ready, b_rvalid, b_rdata,
      input  seg_state, seg_statecase, seg_addr_d, seg_dataW_d, seg_write_d,
      output seg_dataR_d
   );
endinterface
`default_nettype wire

// File: rtl/segrw_arb2_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : segrw_arb2_ctl                                             |
// | Description : Two-requester controller for the SEG_rw segment datapath.  |
// |               Round-robin arbitration between ports A and B, sequencing  |
// |               of the datapath state/statecase inputs, and one-entry      |
// |               read response registers per port.                          |
// | Ports       : clock  - single clock, rising edge                         |
// |               reset  - asynchronous, active-low                          |
// |               bus    - segrw_arb2_ctl_if.slave (requesters + datapath)   |
// | Option      : SEGRW_ARB_WRACK_EN - when defined, write completions also  |
// |               return a response (rdata = 0) and need a free response     |
// |               register before they can execute.                          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module segrw_arb2_ctl #(
   parameter int awidth = 7,
   parameter int dwidth = 7
) (
   input wire               clock,
   input wire               reset,
   segrw_arb2_ctl_if.slave  bus
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   localparam logic [1:0] SC_STALL = 2'd0;
   localparam logic [1:0] SC_CAPT  = 2'd1;   // exec pending op + capture new one
   localparam logic [1:0] SC_EXEC  = 2'd2;   // exec pending op only
   localparam logic       OWN_A    = 1'b0;
   localparam logic       OWN_B    = 1'b1;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_own;
   logic              r_pw;
   logic              r_last;
   logic              r_a_rvalid;
   logic              r_b_rvalid;
   logic [dwidth-1:0] r_a_rdata;
   logic [dwidth-1:0] r_b_rdata;

   logic              w_any;
   logic              w_win;
   logic              w_grant;
   logic              w_exec;
   logic              w_can_exec;
   logic              w_own_rvalid;
   logic              w_own_rready;
   logic              w_resp_load;
   logic [1:0]        w_statecase;
   logic [awidth-1:0] w_sel_addr;
   logic [dwidth-1:0] w_sel_data;
   logic              w_sel_write;
   logic [dwidth-1:0] w_resp_data;

   // Gating with reset keeps ready and statecase at their reset values even
   // while requesters hold valid during reset.
   assign w_any = reset & (bus.a_valid | bus.b_valid);

   // r_last resets to B, so A wins the first contention.
   assign w_win = (bus.a_valid && bus.b_valid) ? ~r_last :
                  (bus.b_valid ? OWN_B : OWN_A);

   assign w_own_rvalid = (r_own == OWN_B) ? r_b_rvalid : r_b_rvalid & 1'b0 | r_a_rvalid;
   assign w_own_rready = (r_own == OWN_B) ? bus.b_rready : bus.a_rready;

   // A held response only blocks the segment if its owner is the pending op.
`ifdef SEGRW_ARB_WRACK_EN
   assign w_can_exec  = ~w_own_rvalid | w_own_rready;
   assign w_resp_load = 1'b1;
`else
   assign w_can_exec  = r_pw | ~w_own_rvalid | w_own_rready;
   assign w_resp_load = ~r_pw;
`endif

   assign w_resp_data = r_pw ? '0 : bus.seg_dataR_d;

   always_comb begin
      w_state_nxt = r_state;
      w_statecase = SC_STALL;
      w_grant     = 1'b0;
      w_exec      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_statecase = SC_CAPT;
               w_grant     = 1'b1;
               w_state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (w_can_exec) begin
               w_exec = 1'b1;
               if (w_any) begin
                  w_statecase = SC_CAPT;
                  w_grant     = 1'b1;
               end else begin
                  w_statecase = SC_EXEC;
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Port A drives the datapath request lines whenever B is not granted.
   assign w_sel_addr  = (w_grant && w_win == OWN_B) ? bus.b_addr  : bus.a_addr;
   assign w_sel_data  = (w_grant && w_win == OWN_B) ? bus.b_dataW : bus.a_dataW;
   assign w_sel_write = (w_grant && w_win == OWN_B) ? bus.b_write : bus.a_write;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_own      <= OWN_A;
         r_pw       <= 1'b0;
         r_last     <= OWN_B;
         r_a_rvalid <= 1'b0;
         r_b_rvalid <= 1'b0;
         r_a_rdata  <= '0;
         r_b_rdata  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant) begin
            r_last <= w_win;
            r_own  <= w_win;
            r_pw   <= w_sel_write;
         end
         // Reload wins over consumption in the same cycle.
         if (w_exec && w_resp_load && r_own == OWN_A) begin
            r_a_rvalid <= 1'b1;
            r_a_rdata  <= w_resp_data;
         end else if (r_a_rvalid && bus.a_rready) begin
            r_a_rvalid <= 1'b0;
         end
         if (w_exec && w_resp_load && r_own == OWN_B) begin
            r_b_rvalid <= 1'b1;
            r_b_rdata  <= w_resp_data;
         end else if (r_b_rvalid && bus.b_rready) begin
            r_b_rvalid <= 1'b0;
         end
      end
   end

   assign bus.a_ready       = w_grant & (w_win == OWN_A);
   assign bus.b_ready       = w_grant & (w_win == OWN_B);
   assign bus.a_rvalid      = r_a_rvalid;
   assign bus.b_rvalid      = r_b_rvalid;
   assign bus.a_rdata       = r_a_rdata;
   assign bus.b_rdata       = r_b_rdata;
   assign bus.seg_state     = (r_state == ST_BUSY);
   assign bus.seg_statecase = w_statecase;
   assign bus.seg_addr_d    = w_sel_addr;
   assign bus.seg_dataW_d   = w_sel_data;
   assign bus.seg_write_d   = w_sel_write;

endmodule
`default_nettype wire

// File: tb/tb_segrw_arb2_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_segrw_arb2_ctl                                          |
// | Description : Self-checking bench for segrw_arb2_ctl. A behavioural      |
// |               SEG_rw datapath drives seg_dataR_d; a transaction-level    |
// |               reference (memory updated in acceptance order, pending op, |
// |               response occupancy) predicts every output each cycle.      |
// |               Honours SEGRW_ARB_WRACK_EN like the design.                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_segrw_arb2_ctl;
   localparam int AW = 7;
   localparam int DW = 7;
`ifdef SEGRW_ARB_WRACK_EN
   localparam bit WRACK = 1'b1;
`else
   localparam bit WRACK = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   segrw_arb2_ctl_if #(.awidth(AW), .dwidth(DW)) bus ();
   segrw_arb2_ctl #(.awidth(AW), .dwidth(DW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] init_val(input int i);
      if (i == 1) return 7'h11;
      if (i == 2) return 7'h22;
      return DW'(i * 3 + 5);
   endfunction

   // ---------------- behavioural SEG_rw datapath ----------------
   logic [DW-1:0] dp_mem [128];
   logic          dp_loaded = 1'b0;
   logic [AW-1:0] dp_a = '0;
   logic [DW-1:0] dp_d = '0;
   logic          dp_w = 1'b0;

   always @(posedge clock) begin
      if (!dp_loaded) begin
         for (int i = 0; i < 128; i++) dp_mem[i] <= init_val(i);
         dp_loaded <= 1'b1;
      end else begin
         // In the start state the captured op is stale and is never executed.
         if (bus.seg_state && (bus.seg_statecase == 2'd1 || bus.seg_statecase == 2'd2) && dp_w)
            dp_mem[dp_a] <= dp_d;
         if (bus.seg_statecase == 2'd1) begin
            dp_a <= bus.seg_addr_d;
            dp_d <= bus.seg_dataW_d;
            dp_w <= bus.seg_write_d;
         end
      end
   end
   assign bus.seg_dataR_d = dp_mem[dp_a];

   // ---------------- reference model ----------------
   logic [DW-1:0] ref_mem [128];
   logic          m_pend, m_own, m_pw, m_last;
   logic [AW-1:0] m_paddr;
   logic [DW-1:0] m_pold, m_pdata;
   logic [1:0]    m_rv;
   logic [DW-1:0] m_rd [2];
   logic [1:0]    obs_sc;
   logic          obs_brv;

   task automatic model_reset();
      m_pend = 1'b0; m_own = 1'b0; m_pw = 1'b0; m_last = 1'b1;
      m_rv = 2'b00; m_rd[0] = '0; m_rd[1] = '0;
   endtask

   task automatic model_step();
      logic av, bv, win, grant, can, wr, orr;
      logic [1:0] sc;
      logic [AW-1:0] ad;
      logic [DW-1:0] dd;
      obs_sc  = bus.seg_statecase;
      obs_brv = bus.b_rvalid;
      if (!reset) begin
         chk("rst_statecase", 32'(bus.seg_statecase), 0);
         chk("rst_state", 32'(bus.seg_state), 0);
         chk("rst_ready", {bus.a_ready, bus.b_ready}, 0);
         chk("rst_rvalid", {bus.a_rvalid, bus.b_rvalid}, 0);
         chk("rst_rdata", {bus.a_rdata, bus.b_rdata}, 0);
         // The discarded pending write never reaches memory.
         if (m_pend && m_pw) ref_mem[m_paddr] = m_pold;
         model_reset();
         return;
      end
      av  = bus.a_valid;
      bv  = bus.b_valid;
      orr = m_own ? bus.b_rready : bus.a_rready;
      can = (m_pw && !WRACK) || !m_rv[m_own] || orr;
      if (!m_pend)   sc = (av || bv) ? 2'd1 : 2'd0;
      else if (!can) sc = 2'd0;
      else           sc = (av || bv) ? 2'd1 : 2'd2;
      grant = (sc == 2'd1);
      win   = (av && bv) ? !m_last : bv;

      chk("statecase", 32'(bus.seg_statecase), 32'(sc));
      chk("seg_state", 32'(bus.seg_state), 32'(m_pend));
      chk("a_ready", 32'(bus.a_ready), 32'(grant && !win));
      chk("b_ready", 32'(bus.b_ready), 32'(grant && win));
      chk("a_rvalid", 32'(bus.a_rvalid), 32'(m_rv[0]));
      chk("b_rvalid", 32'(bus.b_rvalid), 32'(m_rv[1]));
      chk("a_rdata", 32'(bus.a_rdata), 32'(m_rd[0]));
      chk("b_rdata", 32'(bus.b_rdata), 32'(m_rd[1]));

      wr = win ? bus.b_write : bus.a_write;
      ad = win ? bus.b_addr  : bus.a_addr;
      dd = win ? bus.b_dataW : bus.a_dataW;
      if (grant) begin
         chk("seg_addr", 32'(bus.seg_addr_d), 32'(ad));
         chk("seg_write", 32'(bus.seg_write_d), 32'(wr));
         if (wr) chk("seg_dataW", 32'(bus.seg_dataW_d), 32'(dd));
      end

      if (m_rv[0] && bus.a_rready) m_rv[0] = 1'b0;
      if (m_rv[1] && bus.b_rready) m_rv[1] = 1'b0;
      if (m_pend && sc != 2'd0 && (!m_pw || WRACK)) begin
         m_rv[m_own] = 1'b1;
         m_rd[m_own] = m_pdata;
      end
      if (grant) begin
         m_last  = win;
         m_own   = win;
         m_pw    = wr;
         m_paddr = ad;
         m_pold  = ref_mem[ad];
         m_pdata = wr ? '0 : ref_mem[ad];
         if (wr) ref_mem[ad] = dd;
         m_pend  = 1'b1;
      end else if (sc == 2'd2) begin
         m_pend = 1'b0;
      end
   endtask

   // Inputs are set just after a rising edge; checks run on the falling edge.
   task automatic tick();
      @(negedge clock);
      model_step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_a(input logic v, input logic w, input int addr, input int data);
      bus.a_valid = v; bus.a_write = w; bus.a_addr = AW'(addr); bus.a_dataW = DW'(data);
   endtask

   task automatic set_b(input logic v, input logic w, input int addr, input int data);
      bus.b_valid = v; bus.b_write = w; bus.b_addr = AW'(addr); bus.b_dataW = DW'(data);
   endtask

   int            stalls;
   int            acks;
   logic [DW-1:0] old3;

   initial begin
      for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
      model_reset();
      set_a(1'b1, 1'b0, 4, 0);   // valid held during reset must not be granted
      set_b(1'b0, 1'b0, 0, 0);
      bus.a_rready = 1'b1;
      bus.b_rready = 1'b1;
      #1;
      repeat (3) tick();
      reset = 1'b1;
      set_a(1'b0, 1'b0, 0, 0);
      tick();

      // Write then read on one port.
      set_a(1'b1, 1'b1, 5, 'h2A); tick();
      set_a(1'b1, 1'b0, 5, 0);    tick();
      set_a(1'b0, 1'b0, 0, 0);
      repeat (4) tick();

      // Contention: both ports read every cycle.
      set_a(1'b1, 1'b0, 1, 0);
      set_b(1'b1, 1'b0, 2, 0);
      repeat (12) tick();
      set_a(1'b0, 1'b0, 0, 0);
      set_b(1'b0, 1'b0, 0, 0);
      repeat (3) tick();

      // Backpressure on A.
      bus.a_rready = 1'b0;
      set_a(1'b1, 1'b0, 1, 0);
      repeat (6) tick();
      set_a(1'b0, 1'b0, 0, 0);
      tick();
      bus.a_rready = 1'b1;
      repeat (4) tick();

      // Cross-port isolation: B's response held, A streams 4 reads.
      bus.b_rready = 1'b0;
      set_b(1'b1, 1'b0, 2, 0); tick();
      set_b(1'b0, 1'b0, 0, 0);
      stalls = 0;
      for (int i = 0; i < 4; i++) begin
         set_a(1'b1, 1'b0, 10 + i, 0);
         tick();
         if (obs_sc == 2'd0) stalls++;
      end
      set_a(1'b0, 1'b0, 0, 0);
      tick();
      if (obs_sc == 2'd0) stalls++;
      chk("iso_stalls", 32'(stalls), 0);
      bus.b_rready = 1'b1;
      repeat (3) tick();

      // Randomized traffic over a small address window.
      for (int i = 0; i < 250; i++) begin
         set_a(1'($urandom), 1'($urandom_range(0, 3) == 0), $urandom_range(0, 7), $urandom);
         set_b(1'($urandom), 1'($urandom_range(0, 3) == 0), $urandom_range(0, 7), $urandom);
         bus.a_rready = ($urandom_range(0, 9) < 7);
         bus.b_rready = ($urandom_range(0, 9) < 7);
         tick();
      end
      set_a(1'b0, 1'b0, 0, 0);
      set_b(1'b0, 1'b0, 0, 0);
      bus.a_rready = 1'b1;
      bus.b_rready = 1'b1;
      repeat (4) tick();

      // Reset while a write is pending.
      old3 = ref_mem[3];
      set_a(1'b1, 1'b1, 3, 'h7F); tick();
      reset = 1'b0;
      set_a(1'b0, 1'b0, 0, 0);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      set_a(1'b1, 1'b0, 3, 0); tick();
      set_a(1'b0, 1'b0, 0, 0);
      repeat (4) tick();
      chk("mem3_kept", 32'(dp_mem[3]), 32'(old3));

      // Write acknowledge on B.
      set_b(1'b1, 1'b1, 0, 'h01); tick();
      set_b(1'b0, 1'b0, 0, 0);
      acks = 0;
      repeat (4) begin
         tick();
         if (obs_brv) acks++;
      end
      chk("wrack_pulses", 32'(acks), WRACK ? 1 : 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
